// File: rtl/hazard_stall_unit_pkg.sv
// Shared ISA constants, instruction field positions and the multdiv wait-state
// encoding used by the hazard/stall controller.
package hazard_stall_unit_pkg;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 27;
  localparam int RD_HI    = 26;
  localparam int RD_LO    = 22;
  localparam int RS_HI    = 21;
  localparam int RS_LO    = 17;
  localparam int RT_HI    = 16;
  localparam int RT_LO    = 12;
  localparam int ALUOP_HI = 6;
  localparam int ALUOP_LO = 2;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_START = 2'd1,
    MD_WAIT  = 2'd2
  } md_state_t;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side signal bundle of the hazard/stall controller: latched
// instructions, multdiv handshake and the stall/bubble controls.
interface hazard_stall_unit_if;
  logic [31:0] fd_ir;
  logic [31:0] dx_ir;
  logic        md_ready;
  logic        md_exception;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic        stall_front;
  logic        stall_dx;
  logic        bubble_dx;
  logic        bubble_xm;
  logic        md_latch;
  logic        md_timeout;

  modport master (
    output fd_ir, dx_ir, md_ready, md_exception,
    input  ctrl_mult, ctrl_div, stall_front, stall_dx, bubble_dx, bubble_xm,
           md_latch, md_timeout
  );

  modport slave (
    input  fd_ir, dx_ir, md_ready, md_exception,
    output ctrl_mult, ctrl_div, stall_front, stall_dx, bubble_dx, bubble_xm,
           md_latch, md_timeout
  );
endinterface

// File: rtl/hazard_stall_unit_insn_src_decode.sv
// Combinational decode of which registers an instruction reads, plus the
// load/store/multdiv classification the stall logic needs.
module insn_src_decode
  import hazard_stall_unit_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  src_a,
  output logic [4:0]  src_b,
  output logic        uses_a,
  output logic        uses_b,
  output logic        is_lw,
  output logic        is_sw,
  output logic        is_muldiv,
  output logic        is_mul
);
  logic [4:0] opcode;
  logic [4:0] aluop;
  logic       unused_bits;

  assign opcode      = ir[OPC_HI:OPC_LO];
  assign aluop       = ir[ALUOP_HI:ALUOP_LO];
  assign src_a       = ir[RS_HI:RS_LO];
  assign is_lw       = (opcode == OP_LW);
  assign is_sw       = (opcode == OP_SW);
  assign is_mul      = (opcode == OP_ALU) && (aluop == ALU_MUL);
  assign is_muldiv   = (opcode == OP_ALU) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));
  assign unused_bits = ^{ir[11:7], ir[1:0]};

  // Stores and branches compare/store the register named in the rd field.
  always_comb begin
    uses_a = 1'b0;
    uses_b = 1'b0;
    src_b  = ir[RT_HI:RT_LO];
    case (opcode)
      OP_ALU: begin
        uses_a = 1'b1;
        uses_b = 1'b1;
      end
      OP_ADDI, OP_LW: uses_a = 1'b1;
      OP_SW, OP_BNE, OP_BLT: begin
        uses_a = 1'b1;
        uses_b = 1'b1;
        src_b  = ir[RD_HI:RD_LO];
      end
      OP_JR: begin
        uses_b = 1'b1;
        src_b  = ir[RD_HI:RD_LO];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use and multdiv-occupancy stall controller for the 5-stage core; also
// issues the multdiv start pulse and waits for its result (with timeout).
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic               clock,
  input  logic               reset,
  hazard_stall_unit_if.slave hs
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MD_TIMEOUT - 1);

  logic [4:0] fd_src_a, fd_src_b, dx_src_a, dx_src_b, dx_rd;
  logic       fd_uses_a, fd_uses_b, fd_is_lw, fd_is_sw, fd_is_muldiv, fd_is_mul;
  logic       dx_uses_a, dx_uses_b, dx_is_lw, dx_is_sw, dx_is_muldiv, dx_is_mul;
  logic       load_use, sw_bypass, md_issue, md_done, md_hold, md_busy;
  logic       unused_sigs;

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             timeout_q;

  insn_src_decode u_fd_dec (
    .ir(hs.fd_ir), .src_a(fd_src_a), .src_b(fd_src_b), .uses_a(fd_uses_a),
    .uses_b(fd_uses_b), .is_lw(fd_is_lw), .is_sw(fd_is_sw),
    .is_muldiv(fd_is_muldiv), .is_mul(fd_is_mul)
  );

  insn_src_decode u_dx_dec (
    .ir(hs.dx_ir), .src_a(dx_src_a), .src_b(dx_src_b), .uses_a(dx_uses_a),
    .uses_b(dx_uses_b), .is_lw(dx_is_lw), .is_sw(dx_is_sw),
    .is_muldiv(dx_is_muldiv), .is_mul(dx_is_mul)
  );

  assign unused_sigs = ^{dx_src_a, dx_src_b, dx_uses_a, dx_uses_b, dx_is_sw,
                         fd_is_lw, fd_is_muldiv, fd_is_mul, hs.md_exception};

  // A store of the loaded value (base register untouched) is served by the memory bypass.
  assign dx_rd     = hs.dx_ir[RD_HI:RD_LO];
  assign sw_bypass = fd_is_sw && (fd_src_b == dx_rd) && (fd_src_a != dx_rd);
  assign load_use  = dx_is_lw && (dx_rd != 5'd0) && !sw_bypass &&
                     ((fd_uses_a && (fd_src_a == dx_rd)) || (fd_uses_b && (fd_src_b == dx_rd)));

  assign md_issue = (state == MD_IDLE) && dx_is_muldiv;
  assign md_done  = ((state == MD_START) && hs.md_ready) ||
                    ((state == MD_WAIT) && (hs.md_ready || (cnt == LAST)));
  assign md_hold  = md_issue || ((state != MD_IDLE) && !md_done);
  assign md_busy  = md_issue || (state != MD_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= MD_IDLE;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: if (dx_is_muldiv) state <= MD_START;
        MD_START: begin
          cnt   <= '0;
          state <= hs.md_ready ? MD_IDLE : MD_WAIT;
        end
        MD_WAIT: begin
          if (hs.md_ready) begin
            state <= MD_IDLE;
          end else if (cnt == LAST) begin
            state     <= MD_IDLE;
            timeout_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  // Combinational controls are gated by reset so they drop the instant reset asserts.
  assign hs.ctrl_mult   = reset && md_issue && dx_is_mul;
  assign hs.ctrl_div    = reset && md_issue && !dx_is_mul;
  assign hs.stall_front = reset && (md_hold || (load_use && !md_busy));
  assign hs.stall_dx    = reset && md_hold;
  assign hs.bubble_dx   = reset && load_use && !md_busy;
  assign hs.bubble_xm   = reset && md_hold;
  assign hs.md_latch    = reset && md_done;
  assign hs.md_timeout  = timeout_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit with a queue-based scoreboard.
module tb_hazard_stall_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  hazard_stall_unit_if hs_bus ();

  hazard_stall_unit #(.MD_TIMEOUT(64), .CNT_W(7)) dut (
    .clock(clock),
    .reset(reset),
    .hs   (hs_bus)
  );

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  // Output vector: {ctrl_mult, ctrl_div, stall_front, stall_dx, bubble_dx, bubble_xm, md_latch, md_timeout}
  localparam logic [7:0] Z     = 8'b0000_0000;
  localparam logic [7:0] LU    = 8'b0010_1000;
  localparam logic [7:0] MULI  = 8'b1011_0100;
  localparam logic [7:0] DIVI  = 8'b0111_0100;
  localparam logic [7:0] HOLD  = 8'b0011_0100;
  localparam logic [7:0] LATCH = 8'b0000_0010;
  localparam logic [7:0] TO    = 8'b0000_0001;

  logic [31:0] NOP, LW5, LW0, ADD652, ADD602, ADD125, SW53, SW35, SW55;
  logic [31:0] BNE51, JR5, ADDI51, MUL, DIV;

  function automatic logic [31:0] r_type(input logic [4:0] rd, rs, rt, aluop);
    return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] i_type(input logic [4:0] op, rd, rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic cyc(input string nm, input logic [31:0] fd, input logic [31:0] dx,
                     input logic rdy, input logic exc, input logic rst, input logic [7:0] exp);
    exp_t e;
    @(posedge clock);
    #1;
    reset                = rst;
    hs_bus.fd_ir         = fd;
    hs_bus.dx_ir         = dx;
    hs_bus.md_ready      = rdy;
    hs_bus.md_exception  = exc;
    e.name = nm;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      tests++;
      if ({hs_bus.ctrl_mult, hs_bus.ctrl_div, hs_bus.stall_front, hs_bus.stall_dx,
           hs_bus.bubble_dx, hs_bus.bubble_xm, hs_bus.md_latch, hs_bus.md_timeout} !== cur.exp) begin
        fails++;
        $display("FAIL %s: got %b expected %b (mult,div,front,dx,bub_dx,bub_xm,latch,timeout)",
                 cur.name,
                 {hs_bus.ctrl_mult, hs_bus.ctrl_div, hs_bus.stall_front, hs_bus.stall_dx,
                  hs_bus.bubble_dx, hs_bus.bubble_xm, hs_bus.md_latch, hs_bus.md_timeout},
                 cur.exp);
      end
    end
  end

  initial begin
    NOP    = 32'h0;
    LW5    = i_type(5'b01000, 5'd5, 5'd0, 17'd0);
    LW0    = i_type(5'b01000, 5'd0, 5'd0, 17'd0);
    ADD652 = r_type(5'd6, 5'd5, 5'd2, 5'b00000);
    ADD602 = r_type(5'd6, 5'd0, 5'd2, 5'b00000);
    ADD125 = r_type(5'd1, 5'd2, 5'd5, 5'b00000);
    SW53   = i_type(5'b00111, 5'd5, 5'd3, 17'd0);
    SW35   = i_type(5'b00111, 5'd3, 5'd5, 17'd0);
    SW55   = i_type(5'b00111, 5'd5, 5'd5, 17'd0);
    BNE51  = i_type(5'b00010, 5'd5, 5'd1, 17'd8);
    JR5    = i_type(5'b00100, 5'd5, 5'd0, 17'd0);
    ADDI51 = i_type(5'b00101, 5'd5, 5'd1, 17'd3);
    MUL    = r_type(5'd7, 5'd1, 5'd2, 5'b00110);
    DIV    = r_type(5'd8, 5'd3, 5'd4, 5'b00111);
    hs_bus.fd_ir = '0;
    hs_bus.dx_ir = '0;
    hs_bus.md_ready = 1'b0;
    hs_bus.md_exception = 1'b0;

    cyc("reset",       NOP,    NOP, 0, 0, 0, Z);
    cyc("reset_comb",  ADD652, LW5, 0, 0, 0, Z);
    cyc("idle",        NOP,    NOP, 0, 0, 1, Z);

    cyc("lu_stall",    ADD652, LW5, 0, 0, 1, LU);
    cyc("lu_clear",    ADD652, NOP, 0, 0, 1, Z);
    cyc("lu_r0",       ADD602, LW0, 0, 0, 1, Z);
    cyc("lu_rt",       ADD125, LW5, 0, 0, 1, LU);
    cyc("sw_bypass",   SW53,   LW5, 0, 0, 1, Z);
    cyc("sw_base",     SW35,   LW5, 0, 0, 1, LU);
    cyc("sw_both",     SW55,   LW5, 0, 0, 1, LU);
    cyc("bne_rd",      BNE51,  LW5, 0, 0, 1, LU);
    cyc("jr_rd",       JR5,    LW5, 0, 0, 1, LU);
    cyc("addi_dest",   ADDI51, LW5, 0, 0, 1, Z);
    cyc("rdy_in_idle", NOP,    NOP, 1, 0, 1, Z);

    cyc("mul_issue",   ADD652, MUL, 0, 0, 1, MULI);
    repeat (17) cyc("mul_hold", ADD652, MUL, 0, 0, 1, HOLD);
    cyc("mul_latch",   ADD652, MUL, 1, 0, 1, LATCH);
    cyc("mul_after",   NOP,    ADD652, 0, 0, 1, Z);

    cyc("div_issue",   NOP, DIV, 0, 0, 1, DIVI);
    cyc("div_exc",     NOP, DIV, 1, 1, 1, LATCH);
    cyc("b2b_issue",   NOP, MUL, 0, 0, 1, MULI);
    cyc("b2b_start",   NOP, MUL, 0, 0, 1, HOLD);
    repeat (2) cyc("b2b_wait", NOP, MUL, 0, 0, 1, HOLD);
    cyc("b2b_latch",   NOP, MUL, 1, 1, 1, LATCH);
    cyc("no_retrig",   NOP, NOP, 0, 0, 1, Z);

    cyc("to_issue",    NOP, MUL, 0, 0, 1, MULI);
    repeat (64) cyc("to_hold", NOP, MUL, 0, 0, 1, HOLD);
    cyc("to_release",  NOP, MUL, 0, 0, 1, LATCH);
    cyc("to_sticky",   NOP, NOP, 0, 0, 1, TO);
    cyc("to_lu",       ADD652, LW5, 0, 0, 1, LU | TO);
    cyc("to_sticky2",  ADD652, NOP, 0, 0, 1, TO);

    cyc("rst_issue",   NOP, MUL, 0, 0, 1, MULI | TO);
    cyc("rst_start",   NOP, MUL, 0, 0, 1, HOLD | TO);
    repeat (4) cyc("rst_wait", NOP, MUL, 0, 0, 1, HOLD | TO);
    cyc("rst_async",   NOP, MUL, 0, 0, 0, Z);
    cyc("rst_low_rdy", NOP, MUL, 1, 0, 0, Z);
    cyc("rst_release", NOP, NOP, 0, 0, 1, Z);
    cyc("fresh_issue", NOP, MUL, 0, 0, 1, MULI);
    cyc("fresh_latch", NOP, MUL, 1, 0, 1, LATCH);
    cyc("fresh_done",  NOP, NOP, 0, 0, 1, Z);

    for (int i = 0; i < 4 && sb.size() > 0; i++) begin
      @(negedge clock);
      #1;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
